// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions used by the word aligner and the 10b/8b decoder.
package hdmi_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] CTL0 = 10'h354;
  localparam logic [SYM_W-1:0] CTL1 = 10'h0AB;
  localparam logic [SYM_W-1:0] CTL2 = 10'h154;
  localparam logic [SYM_W-1:0] CTL3 = 10'h2AB;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } align_state_e;

endpackage

// File: rtl/hdmi_word_align_if.sv
// Raw deserialiser word in, aligned symbol plus lock/rotation status out.
interface hdmi_word_align_if;
  logic [hdmi_pkg::SYM_W-1:0] i_word;
  logic [hdmi_pkg::SYM_W-1:0] o_word;
  logic                       o_locked;
  logic [3:0]                 o_shift;

  modport master (output i_word, input o_word, o_locked, o_shift);
  modport slave  (input i_word, output o_word, o_locked, o_shift);
endinterface

// File: rtl/hdmi_ctrl_token.sv
// Combinational match of a 10-bit symbol against the four TMDS control tokens.
module hdmi_ctrl_token
  import hdmi_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output logic             o_is_ctl
);

  assign o_is_ctl = (i_sym == CTL0) || (i_sym == CTL1) ||
                    (i_sym == CTL2) || (i_sym == CTL3);

endmodule

// File: rtl/hdmi_word_align.sv
// Per-channel TMDS symbol boundary finder: rotates raw words until a run of
// control tokens is seen, then holds that rotation while runs keep arriving.
module hdmi_word_align
  import hdmi_pkg::*;
#(
  parameter int MIN_RUN   = 8,
  parameter int LGTIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  hdmi_word_align_if.slave   bus
);

  localparam logic [3:0] RUN_MAX   = 4'(MIN_RUN);
  localparam logic [3:0] SHIFT_MAX = 4'd9;

  logic [SYM_W-1:0]     prev_q, word_q, word_d;
  logic [3:0]           shift_q, shift_d;
  logic                 locked_q, locked_d;
  logic [3:0]           run_q, run_d;
  logic [LGTIMEOUT-1:0] tmo_q, tmo_d;
  align_state_e         state_q, state_d;

  logic [2*SYM_W-1:0]   pair;
  logic [SYM_W-1:0]     aligned;
  logic                 is_tok, run_done, expire, shift_chg;

  assign pair    = {bus.i_word, prev_q};
  assign aligned = pair[shift_q +: SYM_W];

  hdmi_ctrl_token u_tok (
    .i_sym    (aligned),
    .o_is_ctl (is_tok)
  );

  // Completion fires only on the token that lifts the run to MIN_RUN, so a
  // saturated run cannot re-trigger until a non-token restarts it.
  assign run_done = is_tok && (run_q == RUN_MAX - 4'd1);
  assign expire   = &tmo_q;

  always_comb begin
    state_d   = state_q;
    locked_d  = locked_q;
    shift_chg = 1'b0;
    word_d    = aligned;
    case (state_q)
      ST_SEARCH: begin
        if (run_done) begin
          state_d  = ST_LOCKED;
          locked_d = 1'b1;
        end else if (expire) begin
          shift_chg = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (!run_done && expire) begin
          state_d   = ST_SEARCH;
          locked_d  = 1'b0;
          shift_chg = 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    shift_d = shift_q;
    if (shift_chg) shift_d = (shift_q == SHIFT_MAX) ? 4'd0 : shift_q + 4'd1;

    run_d = run_q;
    if (shift_chg || !is_tok) run_d = 4'd0;
    else if (run_q != RUN_MAX) run_d = run_q + 4'd1;

    if (run_done || shift_chg || (state_d != state_q)) tmo_d = '0;
    else tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      prev_q   <= '0;
      word_q   <= '0;
      shift_q  <= '0;
      locked_q <= 1'b0;
      run_q    <= '0;
      tmo_q    <= '0;
      state_q  <= ST_SEARCH;
    end else begin
      prev_q   <= bus.i_word;
      word_q   <= word_d;
      shift_q  <= shift_d;
      locked_q <= locked_d;
      run_q    <= run_d;
      tmo_q    <= tmo_d;
      state_q  <= state_d;
    end
  end

  assign bus.o_word   = word_q;
  assign bus.o_locked = locked_q;
  assign bus.o_shift  = shift_q;

endmodule

// File: tb/tb_hdmi_word_align.sv
// Directed bench for hdmi_word_align with a short timeout (64 cycles) and MIN_RUN=8.
module tb_hdmi_word_align;
  import hdmi_pkg::*;

  localparam int MIN_RUN = 8;
  localparam int LGT     = 6;
  localparam logic [9:0] DATA = 10'h1F0;

  logic i_clk     = 1'b0;
  logic i_reset_n = 1'b0;

  hdmi_word_align_if bus ();

  hdmi_word_align #(.MIN_RUN(MIN_RUN), .LGTIMEOUT(LGT)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_chk  = 0;
  int n_fail = 0;
  logic [9:0] wc, wp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raw word that carries symbol s with its true boundary at rotation r.
  function automatic logic [9:0] mk(input logic [9:0] s, input int r);
    logic [9:0] w;
    for (int k = 0; k < 10; k++) w[(r + k) % 10] = s[k];
    return w;
  endfunction

  // Expected aligned symbol from current/previous raw words at rotation r.
  function automatic logic [9:0] align(input logic [9:0] cur, input logic [9:0] prv, input int r);
    logic [9:0] a;
    for (int k = 0; k < 10; k++) a[k] = (r + k < 10) ? prv[r + k] : cur[r + k - 10];
    return a;
  endfunction

  task automatic step(input logic [9:0] w);
    bus.i_word = w;
    @(posedge i_clk);
    #1;
    wp = wc;
    wc = w;
  endtask

  task automatic do_reset(input logic [9:0] w);
    i_reset_n  = 1'b0;
    bus.i_word = w;
    wc = '0;
    wp = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin
    int n;
    int shift_prev;
    logic seen_lock, wrapped;
    logic [9:0] w;
    logic [9:0] mix [5];
    mix[0] = 10'h123; mix[1] = 10'h3FF; mix[2] = 10'h2AB; mix[3] = 10'h001; mix[4] = 10'h2C5;
    bus.i_word = '0;

    // Reset state and aligned CTL0 stream
    do_reset(CTL0);
    chk("rst_word",   32'(bus.o_word),   0);
    chk("rst_locked", 32'(bus.o_locked), 0);
    chk("rst_shift",  32'(bus.o_shift),  0);
    for (int e = 1; e <= 8; e++) step(CTL0);
    chk("t1_nolock_e8", 32'(bus.o_locked), 0);
    step(CTL0);
    chk("t1_lock_e9",  32'(bus.o_locked), 1);
    chk("t1_shift",    32'(bus.o_shift),  0);
    step(CTL0);
    chk("t1_word", 32'(bus.o_word), 32'(CTL0));
    for (int i = 0; i < 5; i++) begin
      step(mix[i]);
      chk("t1_delay2", 32'(bus.o_word), 32'(align(wc, wp, 0)));
    end

    // CTL1 stream with true boundary at rotation 7
    w = mk(CTL1, 7);
    do_reset(w);
    n = 0;
    do begin
      step(w);
      n++;
      if (n == 96)  chk("t2_shift_n96",  32'(bus.o_shift), 1);
      if (n == 288) chk("t2_shift_n288", 32'(bus.o_shift), 4);
    end while (!bus.o_locked && n < 600);
    chk("t2_lock_cyc", n, 456);
    chk("t2_shift",    32'(bus.o_shift), 7);
    step(w);
    chk("t2_word", 32'(bus.o_word), 32'(CTL1));
    for (int i = 0; i < 5; i++) begin
      step(mix[i]);
      chk("t2_rot7", 32'(bus.o_word), 32'(align(wc, wp, 7)));
    end

    // Lock at 3, lose it on data, relock only after wrapping round to 3
    w = mk(CTL0, 3);
    do_reset(w);
    n = 0;
    do begin step(w); n++; end while (!bus.o_locked && n < 400);
    chk("t3_lock_cyc", n, 200);
    chk("t3_shift",    32'(bus.o_shift), 3);
    n = 0;
    do begin step(DATA); n++; end while (bus.o_locked && n < 100);
    chk("t3_drop_cyc",  n, 64);
    chk("t3_drop_shift", 32'(bus.o_shift), 4);
    n = 0;
    do begin step(w); n++; end while (!bus.o_locked && n < 800);
    chk("t3_relock_cyc",   n, 584);
    chk("t3_relock_shift", 32'(bus.o_shift), 3);

    // Asynchronous reset mid-lock, between clock edges
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("t6_async_word",   32'(bus.o_word),   0);
    chk("t6_async_shift",  32'(bus.o_shift),  0);
    chk("t6_async_locked", 32'(bus.o_locked), 0);
    do_reset(CTL0);
    n = 0;
    do begin step(CTL0); n++; end while (!bus.o_locked && n < 20);
    chk("t6_relock_cyc",   n, 9);
    chk("t6_relock_shift", 32'(bus.o_shift), 0);

    // Runs of exactly 7 never lock; shift wraps 9->0; then one 8-run locks
    do_reset(CTL0);
    n = 0;
    seen_lock  = 1'b0;
    wrapped    = 1'b0;
    shift_prev = 0;
    do begin
      step(((n % 8) < 7) ? CTL0 : DATA);
      n++;
      seen_lock = seen_lock | bus.o_locked;
      if (shift_prev == 9 && bus.o_shift == 4'd0) wrapped = 1'b1;
      shift_prev = int'(bus.o_shift);
    end while (!wrapped && n < 800);
    chk("t4_never_lock", 32'(seen_lock), 0);
    chk("t4_wrap_cyc",   n, 640);
    step(DATA);
    for (int i = 0; i < 8; i++) step(CTL0);
    n = 0;
    while (!bus.o_locked && n < 4) begin step(DATA); n++; end
    chk("t4_run8_lock",  32'(bus.o_locked), 1);
    chk("t4_run8_cyc",   n, 1);
    chk("t4_run8_shift", 32'(bus.o_shift), 0);

    // Run completes in the very cycle the timeout expires
    do_reset(DATA);
    for (int e = 1; e <= 64; e++) begin
      step((e >= 56 && e <= 63) ? CTL0 : DATA);
      if (e == 63) chk("t5_pre_locked", 32'(bus.o_locked), 0);
    end
    chk("t5_locked", 32'(bus.o_locked), 1);
    chk("t5_shift",  32'(bus.o_shift),  0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
